bus_array_driver: RTL and testbench
===================================

# bus_array_driver

Self-checking stimulus source and response checker for the `bus_array_test` register cell. It drives pseudo-random vectors onto the cell's A/B/C/D inputs and samples the registered E/F/G/H outputs two cycles later. It compares each response against the value it sent, then reports an error count, the index of the first failing vector, and a pass flag. It sits in the prsim VPI co-simulation bench as the partner of the register cell.

## Interface
- NUM_VECTORS, 16, vectors per run; legal range 1..255
- SEED, 32'h0000_0001, initial LFSR state; 0 is replaced by 32'h0000_0001
- CLK  in  1  clock; all state updates on posedge
- RN  in  1  asynchronous active-low reset
- START  in  1  run request, sampled on posedge CLK
- A  out  1  stimulus to DUT A
- B  out  4  stimulus to DUT B
- C  out  8  stimulus to DUT C
- D  out  32  stimulus to DUT D
- E  in  1  response from DUT E
- F  in  4  response from DUT F
- G  in  8  response from DUT G
- H  in  32  response from DUT H
- BUSY  out  1  run in progress
- DONE  out  1  run complete; held until the next run starts
- ERR_COUNT  out  8  number of mismatching vectors in the run
- FIRST_ERR  out  8  index of the first mismatching vector; 0 if none
- PASS  out  1  DONE && ERR_COUNT==0

## Operation
- One clock, CLK. Reset is asynchronous and active-low on RN.
- RN low forces, immediately:
  - state=IDLE
  - A=0, B=0, C=0, D=0
  - BUSY=0, DONE=0, ERR_COUNT=0, FIRST_ERR=0, PASS=0
  - LFSR=SEED
  - issue and compare indices = 0
  - compare-pipeline valids = 0
- LFSR: 32-bit Galois, right-shift, polynomial 0x80200003.
  - next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
- Vector formed from the current LFSR value s:
  - D = s
  - C = s[15:8]
  - B = s[19:16]
  - A = s[31]
- States:
  - IDLE: BUSY=0. START=1 moves to RUN.
  - RUN: drives one vector per cycle.
  - DRAIN: two cycles flushing the compare pipeline.
  - DONE: DONE=1. START=1 restarts.
- START edge (IDLE or DONE):
  - drive vector 0 from SEED; LFSR<=next(SEED); issue index<=1
  - clear ERR_COUNT, FIRST_ERR and DONE; set BUSY
  - state<=RUN (or DRAIN when NUM_VECTORS==1)
- RUN, each edge:
  - drive the next vector; advance LFSR; increment the issue index
  - after the edge that drives vector NUM_VECTORS-1, state<=DRAIN
- Compare pipeline: two stages of {valid, expected A..D}.
  - Stage 1 = vector currently on the outputs.
  - Stage 2 = vector currently held in the DUT.
  - On each edge with stage-2 valid, compare {E,F,G,H} against stage-2 expected; compare index increments.
- On mismatch:
  - if ERR_COUNT==0, FIRST_ERR<=compare index
  - ERR_COUNT saturating increment; saturation is unreachable because NUM_VECTORS≤255, but is required anyway
- DRAIN: second edge sets DONE=1 and BUSY=0, state<=DONE.
- START while BUSY is ignored.
- A..D hold the last vector after the run, until the next START or reset.

## Timing
- The edge that samples START is edge 0. Vector k appears on A..D after edge k.
- DUT captures vector k at edge k+1. The driver compares it at edge k+2.
- The last compare and the DONE rise happen on the same edge, N+1 (N=NUM_VECTORS). ERR_COUNT and PASS are already final when DONE is first seen high.
- BUSY is high from after edge 0 through edge N+1.
- Restarting from DONE: DONE drops at the START edge, with no gap cycle.
- RN asserted mid-run aborts immediately. No partial results are retained.

## Test plan
- Reset: hold RN=0 while toggling CLK and START → A..D=0, BUSY=0, DONE=0, ERR_COUNT=0, FIRST_ERR=0, PASS=0.
- Clean loopback with a real `bus_array_test`, N=16, SEED=1, START pulse at edge 0 → D=0x00000001 after edge 0, D=0x80200003 after edge 1, DONE rises at edge 17, ERR_COUNT=0, PASS=1.
- Single fault: bench inverts F only while vector 3 is in the DUT → ERR_COUNT=1, FIRST_ERR=3, PASS=0.
- Stuck response: H tied to 0, N=255 → every vector mismatches (the LFSR is never 0), ERR_COUNT=255, FIRST_ERR=0, PASS=0.
- Reset mid-run: N=16, RN low after edge 5 → outputs zero asynchronously. After release, a START gives a full clean run: DONE at edge 17, PASS=1.
- START handling: a START pulse at edge 4 while BUSY changes nothing (DONE still at edge 17). START held high in DONE restarts immediately: DONE drops, a second clean run completes, PASS=1.

Source files
------------

// File: rtl/bus_array_driver.sv
// bus_array_driver: pseudo-random stimulus source and response checker for the
// bus_array_test register cell. Drives one LFSR-derived vector per cycle on
// A..D, checks the registered E..H two cycles later, and reports the error
// count, the first failing vector index and a pass flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START after reset; outputs zero
// S_RUN   | issuing vectors 1..N-1, one per cycle
// S_DRAIN | two cycles letting the last vectors reach the compare stage
// S_DONE  | results valid and held; START restarts immediately
module bus_array_driver #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic        CLK,
  input  logic        RN,
  input  logic        START,
  output logic        A,
  output logic [3:0]  B,
  output logic [7:0]  C,
  output logic [31:0] D,
  input  logic        E,
  input  logic [3:0]  F,
  input  logic [7:0]  G,
  input  logic [31:0] H,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  ERR_COUNT,
  output logic [7:0]  FIRST_ERR,
  output logic        PASS
);

  localparam logic [31:0] POLY     = 32'h8020_0003;
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [7:0]  issue_idx;
  logic [7:0]  cmp_idx;
  logic        drain_second;
  // Stage 1: vector now on A..D. Stage 2: vector now held inside the cell.
  logic        s1_vld;
  logic        s2_vld;
  logic [44:0] s1_exp;
  logic [44:0] s2_exp;
  logic        mismatch;
  logic [7:0]  err_next;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Packed as {A, B, C, D}, matching the {E, F, G, H} response order.
  function automatic logic [44:0] vec_of(input logic [31:0] s);
    return {s[31], s[19:16], s[15:8], s};
  endfunction

  // Compare the cell's response with the vector it captured one edge ago.
  always_comb begin
    mismatch = s2_vld && ({E, F, G, H} != s2_exp);
    err_next = ERR_COUNT;
    if (mismatch && (ERR_COUNT != 8'hFF)) err_next = ERR_COUNT + 8'd1;
  end

  // Sequencer, vector issue, compare pipeline and result registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state        <= S_IDLE;
      {A, B, C, D} <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR_COUNT    <= 8'h0;
      FIRST_ERR    <= 8'h0;
      PASS         <= 1'b0;
      lfsr         <= SEED_EFF;
      issue_idx    <= 8'h0;
      cmp_idx      <= 8'h0;
      drain_second <= 1'b0;
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      s1_exp       <= '0;
      s2_exp       <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_exp <= s1_exp;
      s1_vld <= 1'b0;

      if (mismatch && (ERR_COUNT == 8'h0)) FIRST_ERR <= cmp_idx;
      if (s2_vld) cmp_idx <= cmp_idx + 8'd1;
      ERR_COUNT <= err_next;

      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            {A, B, C, D} <= vec_of(SEED_EFF);
            s1_vld       <= 1'b1;
            s1_exp       <= vec_of(SEED_EFF);
            lfsr         <= lfsr_next(SEED_EFF);
            issue_idx    <= 8'd1;
            cmp_idx      <= 8'h0;
            ERR_COUNT    <= 8'h0;
            FIRST_ERR    <= 8'h0;
            DONE         <= 1'b0;
            PASS         <= 1'b0;
            BUSY         <= 1'b1;
            drain_second <= 1'b0;
            if (NUM_VECTORS == 1) state <= S_DRAIN;
            else                  state <= S_RUN;
          end
        end
        S_RUN: begin
          {A, B, C, D} <= vec_of(lfsr);
          s1_vld       <= 1'b1;
          s1_exp       <= vec_of(lfsr);
          lfsr         <= lfsr_next(lfsr);
          issue_idx    <= issue_idx + 8'd1;
          drain_second <= 1'b0;
          if (issue_idx == LAST_IDX) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!drain_second) begin
            drain_second <= 1'b1;
          end else begin
            // The last compare lands on this same edge, so use err_next.
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            PASS  <= (err_next == 8'h0);
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_array_driver.sv
// Bench for bus_array_driver: two instances (N=16 seed 1, N=255 seed 0) each
// looped through a behavioural register cell with optional response faults.
module tb_bus_array_driver;

  logic CLK     = 1'b0;
  logic RN      = 1'b0;
  logic START_s = 1'b0;
  logic START_b = 1'b0;

  logic        A_s, E_s, BUSY_s, DONE_s, PASS_s;
  logic [3:0]  B_s, F_s;
  logic [7:0]  C_s, G_s, ERR_s, FIRST_s;
  logic [31:0] D_s, H_s;

  logic        A_b, E_b, BUSY_b, DONE_b, PASS_b;
  logic [3:0]  B_b, F_b;
  logic [7:0]  C_b, G_b, ERR_b, FIRST_b;
  logic [31:0] D_b, H_b;

  logic [44:0] q_s = '0;
  logic [44:0] q_b = '0;
  logic [31:0] fault_val [8];
  int          fault_n    = 0;
  logic [44:0] fault_mask = '0;
  logic        h_stuck    = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 CLK = ~CLK;

  bus_array_driver #(.NUM_VECTORS(16), .SEED(32'h0000_0001)) u_small (
    .CLK(CLK), .RN(RN), .START(START_s),
    .A(A_s), .B(B_s), .C(C_s), .D(D_s),
    .E(E_s), .F(F_s), .G(G_s), .H(H_s),
    .BUSY(BUSY_s), .DONE(DONE_s), .ERR_COUNT(ERR_s), .FIRST_ERR(FIRST_s), .PASS(PASS_s)
  );

  bus_array_driver #(.NUM_VECTORS(255), .SEED(32'h0000_0000)) u_big (
    .CLK(CLK), .RN(RN), .START(START_b),
    .A(A_b), .B(B_b), .C(C_b), .D(D_b),
    .E(E_b), .F(F_b), .G(G_b), .H(H_b),
    .BUSY(BUSY_b), .DONE(DONE_b), .ERR_COUNT(ERR_b), .FIRST_ERR(FIRST_b), .PASS(PASS_b)
  );

  // Behavioural bus_array_test cells: one-cycle registers.
  always @(posedge CLK) begin
    q_s <= {A_s, B_s, C_s, D_s};
    q_b <= {A_b, B_b, C_b, D_b};
  end

  // Corrupt the small cell's response while a chosen vector is held in it.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (i < fault_n && fault_val[i] == q_s[31:0]) hit = 1'b1;
    {E_s, F_s, G_s, H_s} = hit ? (q_s ^ fault_mask) : q_s;
  end

  assign {E_b, F_b, G_b} = q_b[44:32];
  assign H_b = h_stuck ? 32'h0 : q_b[31:0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] nth_val(input logic [31:0] seed, input int k);
    logic [31:0] s;
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int i = 0; i < k; i++) s = lfsr_nx(s);
    return s;
  endfunction

  function automatic logic [44:0] obs_vec(input int sel);
    return (sel != 0) ? {A_b, B_b, C_b, D_b} : {A_s, B_s, C_s, D_s};
  endfunction

  // {BUSY, DONE, ERR_COUNT, FIRST_ERR, PASS}
  function automatic logic [18:0] obs_stat(input int sel);
    return (sel != 0) ? {BUSY_b, DONE_b, ERR_b, FIRST_b, PASS_b}
                      : {BUSY_s, DONE_s, ERR_s, FIRST_s, PASS_s};
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) START_b = v;
    else          START_s = v;
  endtask

  // One run: START sampled at the next edge (edge 0), checks through edge N+1.
  task automatic do_run(input int sel, input int n, input logic [31:0] seed, input bit hold,
                        input int pulse_at, input int exp_err, input int exp_first);
    logic [31:0] s;
    logic [44:0] last;
    logic [18:0] st;
    s    = (seed == 32'h0) ? 32'h1 : seed;
    last = '0;
    st   = '0;
    set_start(sel, 1'b1);
    for (int e = 0; e <= n + 1; e++) begin
      @(posedge CLK); #1;
      if (e == 0 && !hold) set_start(sel, 1'b0);
      if (e == pulse_at - 1) set_start(sel, 1'b1);
      if (e == pulse_at) set_start(sel, 1'b0);
      st = obs_stat(sel);
      chk("busy", 64'(st[18]), 64'(e <= n));
      chk("done", 64'(st[17]), 64'(e == n + 1));
      if (e < n) begin
        last = {s[31], s[19:16], s[15:8], s};
        s = lfsr_nx(s);
      end
      chk("vector", 64'(obs_vec(sel)), 64'(last));
    end
    chk("err_count", 64'(st[16:9]), 64'(exp_err));
    chk("first_err", 64'(st[8:1]), 64'(exp_first));
    chk("pass", 64'(st[0]), 64'(exp_err == 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx [$];
    int nf, k, cnt, first, pulse;
    logic [31:0] s;
    bit dup;

    // Reset held while START toggles.
    RN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      START_s = 1'($urandom);
      START_b = 1'($urandom);
      #1;
      chk("rst_vec_s", 64'(obs_vec(0)), 64'h0);
      chk("rst_stat_s", 64'(obs_stat(0)), 64'h0);
    end
    chk("rst_vec_b", 64'(obs_vec(1)), 64'h0);
    chk("rst_stat_b", 64'(obs_stat(1)), 64'h0);
    @(negedge CLK);
    START_s = 1'b0;
    START_b = 1'b0;
    RN = 1'b1;
    @(negedge CLK);

    // Clean loopback; explicit first two D values.
    do_run(0, 16, 32'h1, 1'b0, -1, 0, 0);
    chk("lfsr_step1", 64'(lfsr_nx(32'h1)), 64'h8020_0003);

    // Only F inverted while vector 3 is in the cell.
    fault_n = 1;
    fault_val[0] = nth_val(32'h1, 3);
    fault_mask = {1'b0, 4'hF, 8'h0, 32'h0};
    do_run(0, 16, 32'h1, 1'b0, -1, 1, 3);
    fault_n = 0;

    // START pulse at edge 4 while busy is ignored.
    do_run(0, 16, 32'h1, 1'b0, 4, 0, 0);

    // START held high through DONE restarts with no gap.
    do_run(0, 16, 32'h1, 1'b1, -1, 0, 0);
    do_run(0, 16, 32'h1, 1'b0, -1, 0, 0);

    // Randomized fault sets and stray START pulses.
    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(0, 3);
      idx.delete();
      for (int j = 0; j < nf; j++) begin
        k = $urandom_range(0, 15);
        dup = 1'b0;
        foreach (idx[m]) if (idx[m] == k) dup = 1'b1;
        if (!dup) idx.push_back(k);
      end
      fault_mask = 45'({$urandom(), $urandom()});
      if (fault_mask == '0) fault_mask = 45'h1;
      first = 16;
      foreach (idx[m]) begin
        fault_val[m] = nth_val(32'h1, idx[m]);
        if (idx[m] < first) first = idx[m];
      end
      fault_n = idx.size();
      if (fault_n == 0) first = 0;
      pulse = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 15)) : -1;
      do_run(0, 16, 32'h1, 1'b0, pulse, fault_n, first);
      fault_n = 0;
    end

    // Reset mid-run with a fault already counted, then a clean run.
    fault_n = 1;
    fault_val[0] = nth_val(32'h1, 1);
    fault_mask = 45'h1;
    START_s = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      @(posedge CLK); #1;
      if (e == 0) START_s = 1'b0;
    end
    chk("pre_reset_err", 64'(ERR_s), 64'h1);
    RN = 1'b0;
    #1;
    chk("abort_vec", 64'(obs_vec(0)), 64'h0);
    chk("abort_stat", 64'(obs_stat(0)), 64'h0);
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_hold_stat", 64'(obs_stat(0)), 64'h0);
    @(negedge CLK);
    RN = 1'b1;
    fault_n = 0;
    @(negedge CLK);
    do_run(0, 16, 32'h1, 1'b0, -1, 0, 0);

    // N=255, seed 0 (treated as 1), H stuck at zero.
    h_stuck = 1'b1;
    s = 32'h1;
    cnt = 0;
    first = -1;
    for (int v = 0; v < 255; v++) begin
      if (s != 32'h0) begin
        if (cnt < 255) cnt++;
        if (first < 0) first = v;
      end
      s = lfsr_nx(s);
    end
    if (first < 0) first = 0;
    do_run(1, 255, 32'h0, 1'b0, -1, cnt, first);
    h_stuck = 1'b0;
    do_run(1, 255, 32'h0, 1'b0, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
